// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue wrapper.
//   - opcode / operand / result widths
//   - 4-bit opcode constants (4'b0000..4'b1010; 4'b1011..4'b1111 are unused)
//   - packed command type {sel, b, a} as stored in the command FIFO
//   - is_divzero(): true for div/mod commands whose divisor is zero
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_INC  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0011;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOD  = 4'b0101;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0110;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_NAND = 4'b1000;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;

  typedef struct packed {
    logic [OP_W-1:0]   sel;
    logic [OPND_W-1:0] b;
    logic [OPND_W-1:0] a;
  } alu_cmd_t;

  function automatic logic is_divzero(input alu_cmd_t c);
    return ((c.sel == OP_DIV) || (c.sel == OP_MOD)) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t entries.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   push_i          write push_data_i (ignored while full)
//   push_data_i     command to store
//   pop_i           advance read pointer (ignored while empty)
//   pop_data_o      head entry (combinational read of the head slot)
//   full_o/empty_o  occupancy flags, derived from the registered level only
//   level_o         occupancy 0..DEPTH
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  alu_cmd_t                 push_data_i,
  input  logic                     pop_i,
  output alu_cmd_t                 pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  alu_cmd_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle, so ready
  // never depends combinationally on the consumer side.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands, issues them one at a time to the
// external combinational ALU and registers each result on a valid/ready
// response port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready = !full)
//   cmd_a, cmd_b, cmd_sel         command operands and opcode
//   alu_a, alu_b, alu_sel         registered drive to the ALU
//   alu_out                       ALU result (combinational from alu_*)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_sel, rsp_err    registered result, its opcode, div/mod-by-0 flag
//   level                         command FIFO occupancy
// Build option: define ALU_DIVZERO_CHECK_EN to replace div/mod-by-zero
// results with 16'hFFFF and raise rsp_err; otherwise rsp_err is constant 0.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_a,
  input  logic [7:0]                    cmd_b,
  input  logic [3:0]                    cmd_sel,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  output logic [3:0]                    alu_sel,
  input  logic [15:0]                   alu_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_data,
  output logic [3:0]                    rsp_sel,
  output logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  alu_cmd_t         alu_cmd_q, alu_cmd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_data_q, rsp_data_d;
  logic [OP_W-1:0]  rsp_sel_q, rsp_sel_d;

  alu_cmd_t         push_cmd;
  alu_cmd_t         head_cmd;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign push_cmd = '{sel: cmd_sel, b: cmd_b, a: cmd_a};

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cmd_valid),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_cmd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign cmd_ready = !fifo_full;

`ifdef ALU_DIVZERO_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    alu_cmd_d   = alu_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    fifo_pop    = 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          alu_cmd_d = head_cmd;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rsp_valid_d = 1'b1;
        rsp_sel_d   = alu_cmd_q.sel;
`ifdef ALU_DIVZERO_CHECK_EN
        if (is_divzero(alu_cmd_q)) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
        end
`else
        rsp_data_d  = alu_out;
`endif
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // Accepting a response and issuing the next command share one edge,
        // giving one result every two cycles under continuous ready.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            alu_cmd_d = head_cmd;
            state_d   = ST_ISSUE;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_cmd_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_cmd_q   <= alu_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
    end
  end

`ifdef ALU_DIVZERO_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_err_q <= 1'b0;
    else     rsp_err_q <= rsp_err_d;
  end
`endif

  assign alu_a     = alu_cmd_q.a;
  assign alu_b     = alu_cmd_q.b;
  assign alu_sel   = alu_cmd_q.sel;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sel   = rsp_sel_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  cmd_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_sel;
  logic        rsp_err;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  // Fill test commands and hand-computed results.
  logic [7:0]  fa [5] = '{8'd50,  8'd1,   8'hF0,  8'hF0,  8'd9};
  logic [7:0]  fb [5] = '{8'd20,  8'd2,   8'h3C,  8'h3C,  8'd0};
  logic [3:0]  fs [5] = '{4'h2,   4'h0,   4'hA,   4'h6,   4'h1};
  logic [15:0] fe [5] = '{16'h001E, 16'h0003, 16'h00CC, 16'h0030, 16'h000A};

  // Wrap stream commands and hand-computed results.
  logic [7:0]  sa [10] = '{8'd255, 8'd255, 8'd3, 8'd16, 8'd100, 8'd100, 8'h0F, 8'hFF, 8'h0F, 8'hAA};
  logic [7:0]  sb [10] = '{8'd255, 8'd0,   8'd5, 8'd16, 8'd7,   8'd7,   8'hA0, 8'h0F, 8'hA0, 8'h55};
  logic [3:0]  ss [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA};
  logic [15:0] se [10] = '{16'h01FE, 16'h0100, 16'hFFFE, 16'h0100, 16'h000E,
                           16'h0002, 16'h00AF, 16'h00F0, 16'h0050, 16'h00FF};

  alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_sel   (rsp_sel),
    .rsp_err   (rsp_err),
    .level     (level)
  );

  // Stand-in for the combinational ALU driven by the DUT.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
    case (s)
      4'h0: return {8'h00, a} + {8'h00, b};
      4'h1: return {8'h00, a} + 16'd1;
      4'h2: return {8'h00, a} - {8'h00, b};
      4'h3: return {8'h00, a} * {8'h00, b};
      4'h4: return (b == 8'd0) ? 16'd0 : {8'h00, a / b};
      4'h5: return (b == 8'd0) ? 16'd0 : {8'h00, a % b};
      4'h6: return {8'h00, a & b};
      4'h7: return {8'h00, a | b};
      4'h8: return {8'h00, ~(a & b)};
      4'h9: return {8'h00, ~(a | b)};
      4'hA: return {8'h00, a ^ b};
      default: return 16'd0;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single command through an idle block with rsp_ready high.
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [15:0] exp_d, input logic exp_e);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s;
    tick();
    cmd_valid = 1'b0;
    chk({tag, "_v0"}, 16'(rsp_valid), 16'd0);
    tick();
    chk({tag, "_v1"}, 16'(rsp_valid), 16'd0);
    tick();
    chk({tag, "_valid"}, 16'(rsp_valid), 16'd1);
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_sel"}, 16'(rsp_sel), 16'(s));
    chk({tag, "_err"}, 16'(rsp_err), 16'(exp_e));
    tick();
    chk({tag, "_done"}, 16'(rsp_valid), 16'd0);
  endtask

  initial begin
    int  sidx;
    int  ridx;
    logic fire;

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b0;
    tick();
    tick();
    // Reset state.
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_b", 16'(alu_b), 16'd0);
    chk("rst_alu_sel", 16'(alu_sel), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_data", rsp_data, 16'd0);
    chk("rst_rsp_sel", 16'(rsp_sel), 16'd0);
    chk("rst_rsp_err", 16'(rsp_err), 16'd0);
    rst = 1'b0;
    tick();

    // Single add, latency check.
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'd200; cmd_b = 8'd100; cmd_sel = 4'h0;
    tick();
    cmd_valid = 1'b0;
    chk("add_level_push", 16'(level), 16'd1);
    chk("add_valid_n0", 16'(rsp_valid), 16'd0);
    tick();
    chk("add_alu_a", 16'(alu_a), 16'd200);
    chk("add_alu_b", 16'(alu_b), 16'd100);
    chk("add_level_pop", 16'(level), 16'd0);
    chk("add_valid_n1", 16'(rsp_valid), 16'd0);
    tick();
    chk("add_valid", 16'(rsp_valid), 16'd1);
    chk("add_data", rsp_data, 16'd300);
    chk("add_sel", 16'(rsp_sel), 16'd0);
    tick();
    chk("add_done", 16'(rsp_valid), 16'd0);

    // Back-pressure: mul held stable.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'd255; cmd_b = 8'd255; cmd_sel = 4'h3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mul_valid", 16'(rsp_valid), 16'd1);
    chk("mul_data", rsp_data, 16'hFE01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mul_hold_valid", 16'(rsp_valid), 16'd1);
      chk("mul_hold_data", rsp_data, 16'hFE01);
      chk("mul_hold_sel", 16'(rsp_sel), 16'h3);
    end
    rsp_ready = 1'b1;
    tick();
    chk("mul_done", 16'(rsp_valid), 16'd0);
    rsp_ready = 1'b0;
    tick();

    // Fill: 5 accepted (4 buffered + 1 issued), then full.
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", 16'(cmd_ready), 16'd1);
      cmd_valid = 1'b1; cmd_a = fa[i]; cmd_b = fb[i]; cmd_sel = fs[i];
      tick();
    end
    chk("fill_full_ready", 16'(cmd_ready), 16'd0);
    chk("fill_level", 16'(level), 16'd4);
    cmd_a = 8'd99; cmd_b = 8'd1; cmd_sel = 4'h0;
    tick();
    cmd_valid = 1'b0;
    chk("fill_reject_level", 16'(level), 16'd4);
    chk("fill_rsp0_valid", 16'(rsp_valid), 16'd1);
    chk("fill_rsp0_data", rsp_data, fe[0]);
    chk("fill_rsp0_sel", 16'(rsp_sel), 16'(fs[0]));
    rsp_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("drain_gap", 16'(rsp_valid), 16'd0);
      chk("drain_alu_a", 16'(alu_a), 16'(fa[i]));
      if (i == 1) begin
        chk("drain_level", 16'(level), 16'd3);
        chk("drain_ready", 16'(cmd_ready), 16'd1);
      end
      tick();
      chk("drain_valid", 16'(rsp_valid), 16'd1);
      chk("drain_data", rsp_data, fe[i]);
      chk("drain_sel", 16'(rsp_sel), 16'(fs[i]));
    end
    tick();
    chk("drain_end_valid", 16'(rsp_valid), 16'd0);
    tick();
    chk("drain_no_extra", 16'(rsp_valid), 16'd0);
    chk("drain_level0", 16'(level), 16'd0);

    // Divide / modulo by zero and illegal opcode.
`ifdef ALU_DIVZERO_CHECK_EN
    run_one("div0", 8'd7, 8'd0, 4'h4, 16'hFFFF, 1'b1);
    run_one("mod0", 8'd7, 8'd0, 4'h5, 16'hFFFF, 1'b1);
`else
    run_one("div0", 8'd7, 8'd0, 4'h4, 16'h0000, 1'b0);
    run_one("mod0", 8'd7, 8'd0, 4'h5, 16'h0000, 1'b0);
`endif
    run_one("div_ok", 8'd100, 8'd7, 4'h4, 16'h000E, 1'b0);
    run_one("illegal", 8'd5, 8'd6, 4'hC, 16'h0000, 1'b0);

    // Pointer wrap: 10 streamed commands, results in order.
    sidx = 0;
    ridx = 0;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && ridx < 10; cyc++) begin
      if (sidx < 10) begin
        cmd_valid = 1'b1; cmd_a = sa[sidx]; cmd_b = sb[sidx]; cmd_sel = ss[sidx];
      end else begin
        cmd_valid = 1'b0;
      end
      fire = cmd_valid && cmd_ready;
      tick();
      if (fire) sidx++;
      if (rsp_valid) begin
        chk("stream_data", rsp_data, se[ridx]);
        chk("stream_sel", 16'(rsp_sel), 16'(ss[ridx]));
        chk("stream_err", 16'(rsp_err), 16'd0);
        ridx++;
      end
    end
    cmd_valid = 1'b0;
    chk("stream_count", 16'(ridx), 16'd10);
    tick();
    tick();

    // Reset in HOLD with 2 entries queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 8'(i + 1); cmd_b = 8'(i + 1); cmd_sel = 4'h0;
      tick();
    end
    cmd_valid = 1'b0;
    chk("hold_valid", 16'(rsp_valid), 16'd1);
    chk("hold_data", rsp_data, 16'd2);
    chk("hold_level", 16'(level), 16'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(rsp_valid), 16'd0);
    chk("arst_level", 16'(level), 16'd0);
    chk("arst_ready", 16'(cmd_ready), 16'd1);
    chk("arst_alu_a", 16'(alu_a), 16'd0);
    chk("arst_data", rsp_data, 16'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_valid", 16'(rsp_valid), 16'd0);
      chk("post_rst_level", 16'(level), 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
